// File: rtl/matrix_result_tx.sv
// UART 8N1 transmitter for a 2x2 result matrix. It sends the frame SYNC, C00, C01, C10, C11, CHK,
// where CHK is the XOR of the four elements. The elements are captured when the request is accepted.
module matrix_result_tx #(
    parameter int         CLKS_PER_BIT = 1250,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic       send,
    input  logic [7:0] C00,
    input  logic [7:0] C01,
    input  logic [7:0] C10,
    input  logic [7:0] C11,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    localparam int             BW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_cnt;
    logic [2:0]    byte_idx;
    logic [7:0]    c00_q;
    logic [7:0]    c01_q;
    logic [7:0]    c10_q;
    logic [7:0]    c11_q;
    logic [7:0]    chk_q;
    logic [7:0]    cur_byte;
    logic [2:0]    next_bit;
    logic          baud_wrap;

    assign state_dbg = state;
    assign next_bit  = bit_cnt + 3'd1;
    assign baud_wrap = (baud_cnt == BAUD_LAST);

    always_comb begin
        cur_byte = SYNC_BYTE;
        case (byte_idx)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = c00_q;
            3'd2:    cur_byte = c01_q;
            3'd3:    cur_byte = c10_q;
            3'd4:    cur_byte = c11_q;
            3'd5:    cur_byte = chk_q;
            default: cur_byte = SYNC_BYTE;
        endcase
    end

    // tx is registered, so each branch loads the level of the bit that starts on this edge.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= 3'd0;
            byte_idx <= 3'd0;
            c00_q    <= 8'd0;
            c01_q    <= 8'd0;
            c10_q    <= 8'd0;
            c11_q    <= 8'd0;
            chk_q    <= 8'd0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE) begin
                baud_cnt <= baud_wrap ? '0 : baud_cnt + 1'b1;
            end
            case (state)
                IDLE: begin
                    tx   <= 1'b1;
                    busy <= 1'b0;
                    if (send) begin
                        c00_q    <= C00;
                        c01_q    <= C01;
                        c10_q    <= C10;
                        c11_q    <= C11;
                        chk_q    <= C00 ^ C01 ^ C10 ^ C11;
                        byte_idx <= 3'd0;
                        bit_cnt  <= 3'd0;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    if (baud_wrap) begin
                        bit_cnt <= 3'd0;
                        tx      <= cur_byte[0];
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_wrap) begin
                        if (bit_cnt == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            bit_cnt <= next_bit;
                            tx      <= cur_byte[next_bit];
                        end
                    end
                end
                STOP: begin
                    if (baud_wrap) begin
                        bit_cnt <= 3'd0;
                        if (byte_idx == 3'd5) begin
                            byte_idx <= 3'd0;
                            tx       <= 1'b1;
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            tx       <= 1'b0;
                            state    <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/matrix_result_tx.md
MATRIX_RESULT_TX -- requirements
Module: matrix_result_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, default 1250, clock cycles per UART bit period; legal values are 2 or more.
REQ-002 SHALL have parameter: SYNC_BYTE, default 8'hA5, frame header byte.
REQ-003 SHALL have port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port: nRST  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port: send  input  1  frame request, sampled on each rising clk edge.
REQ-006 SHALL have ports: C00, C01, C10, C11  input  8 each  matrix result elements to transmit.
REQ-007 SHALL have port: tx  output  1  UART 8N1 serial line; idle level is high.
REQ-008 SHALL have port: busy  output  1  high while a frame is in progress.
REQ-009 SHALL have port: done  output  1  one-cycle pulse marking frame completion.

Function
REQ-010 SHALL transmit a 6-byte frame in this order: SYNC_BYTE, C00, C01, C10, C11, CHK.
REQ-011 SHALL compute CHK as C00 ^ C01 ^ C10 ^ C11, with SYNC_BYTE excluded from the XOR.
REQ-012 SHALL capture C00..C11 and CHK into internal registers on the accept edge; input changes during a frame SHALL NOT affect the bytes sent.
REQ-013 SHALL accept send only when busy=0; send while busy=1 SHALL be ignored, with no queuing.
REQ-014 SHALL treat send as level-sampled: if send is still high when busy falls, a new frame SHALL start.
REQ-015 SHALL use an FSM with states IDLE, START, DATA, STOP.
- IDLE -> START on accept.
- START -> DATA after CLKS_PER_BIT cycles.
- DATA -> STOP after 8 bits.
- STOP -> START (next byte) or -> IDLE (after byte 6).
REQ-016 SHALL use registered outputs: send high at edge k gives tx=0 and busy=1 from edge k onward (visible in cycle k+1).
REQ-017 SHALL hold each bit on tx for exactly CLKS_PER_BIT cycles, using a baud counter that runs 0..CLKS_PER_BIT-1 and wraps.
REQ-018 SHALL frame each byte as: start bit 0, then data bits LSB first, then one stop bit 1.
REQ-019 SHALL NOT insert idle gaps between bytes; the total frame is exactly 60*CLKS_PER_BIT cycles from the first start bit to the end of the last stop bit.
REQ-020 SHALL hold tx=1 whenever the state is IDLE.
REQ-021 SHALL pulse done high for exactly one cycle at the edge where STOP of byte 6 completes; busy SHALL fall on that same edge.
REQ-022 SHALL accept a send asserted during the done cycle on the next edge, giving back-to-back frames with one idle-high cycle between them.
REQ-023 SHALL use a byte index 0..5 and a bit counter 0..7; neither SHALL exceed its range, and both SHALL clear when a new frame is accepted.

Reset
REQ-024 SHALL, while nRST=0, immediately force: tx=1, busy=0, done=0, state=IDLE, all counters 0, and the capture registers to 0.
REQ-025 SHALL, on reset asserted mid-frame, abort the frame: tx returns high at once, no done pulse is generated, and the remaining bytes are discarded.
REQ-026 SHALL, after nRST deasserts, accept a frame only on a send sampled at a subsequent rising edge.

Verification
REQ-027 SHALL cover basic frame: CLKS_PER_BIT=4, C=01,02,04,08, send 1 cycle -> tx bytes A5,01,02,04,08,0F; done asserted 240 cycles after the accept edge; busy high for those 240 cycles.
REQ-028 SHALL cover input stability: C=FF,00,AA,55, then change all inputs to 00 one cycle after accept -> bytes A5,FF,00,AA,55,00 are still sent.
REQ-029 SHALL cover ignored request: pulse send again at cycle 50 of a frame -> exactly one frame is sent, with one done pulse.
REQ-030 SHALL cover back-to-back: send held high continuously -> two frames separated by exactly one tx=1 idle cycle, with two done pulses.
REQ-031 SHALL cover reset mid-frame: assert nRST=0 during byte 3 data bits -> tx=1 and busy=0 immediately with no done pulse; after release, a new send produces a complete valid frame.
REQ-032 SHALL cover bit timing: CLKS_PER_BIT=2, C00=80 -> every tx bit is exactly 2 cycles wide; the C00 byte shows seven 0 bits, then 1 as bit 7, then the stop bit.
